// File: rtl/ysyx_25020042_muldiv.sv
// Iterative RISC-V M-extension multiply/divide unit: one shift-add or restoring
// shift-subtract step per clock, with valid/ready handshakes and a flush input.
module ysyx_25020042_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0]   ZERO_W   = '0;
  localparam logic [WIDTH-1:0]   ONES_W   = '1;
  localparam logic [WIDTH-1:0]   MIN_W    = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [2*WIDTH-1:0] ZERO_2W  = '0;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2:0]         op_q, op_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   out_q, out_d;

  logic               s1Signed, s2Signed, s1Neg, s2Neg;
  logic               divZero, divOvf, special, negAcc;
  logic [WIDTH-1:0]   mag1, mag2, specRes, remVal, finRes;
  logic [WIDTH:0]     addSum, trial;
  logic [2*WIDTH-1:0] mulNext, divNext, stepNext, finVal;

  // Operand signedness follows funct3; the datapath only ever sees magnitudes.
  assign s1Signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
  assign s2Signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
  assign s1Neg    = s1Signed & src1[WIDTH-1];
  assign s2Neg    = s2Signed & src2[WIDTH-1];
  assign mag1     = s1Neg ? (ZERO_W - src1) : src1;
  assign mag2     = s2Neg ? (ZERO_W - src2) : src2;
  assign negAcc   = (op[2] && op[1]) ? s1Neg : (s1Neg ^ s2Neg);

  assign divZero  = op[2] && (src2 == ZERO_W);
  assign divOvf   = op[2] && !op[0] && (src1 == MIN_W) && (src2 == ONES_W);
  assign special  = divZero || divOvf;
  assign specRes  = op[1] ? (divZero ? src1 : ZERO_W) : (divZero ? ONES_W : src1);

  // Multiply: add the multiplicand into the high half when the low bit is set, then shift right.
  assign addSum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? mcand_q : ZERO_W)};
  assign mulNext  = {addSum, prod_q[WIDTH-1:1]};

  // Divide: high half is the partial remainder, low half shifts dividend bits out and quotient bits in.
  assign trial    = prod_q[2*WIDTH-1:WIDTH-1] - {1'b0, mcand_q};
  assign divNext  = trial[WIDTH] ? {prod_q[2*WIDTH-2:0], 1'b0}
                                 : {trial[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};

  assign stepNext = op_q[2] ? divNext : mulNext;
  assign finVal   = neg_q ? (ZERO_2W - stepNext) : stepNext;
  assign remVal   = neg_q ? (ZERO_W - stepNext[2*WIDTH-1:WIDTH]) : stepNext[2*WIDTH-1:WIDTH];

  // Negating the full product gives the signed high half; its low half is also the negated quotient.
  always_comb begin
    finRes = finVal[WIDTH-1:0];
    case (op_q)
      3'b001, 3'b010, 3'b011: finRes = finVal[2*WIDTH-1:WIDTH];
      3'b110, 3'b111:         finRes = remVal;
      default:                finRes = finVal[WIDTH-1:0];
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    mcand_d = mcand_q;
    op_d    = op_q;
    neg_d   = neg_q;
    out_d   = out_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_d    = op;
            mcand_d = mag2;
            neg_d   = negAcc;
            cnt_d   = '0;
            if (special) begin
              out_d   = specRes;
              state_d = DONE;
            end else begin
              prod_d  = {ZERO_W, mag1};
              state_d = BUSY;
            end
          end
        end
        BUSY: begin
          prod_d = stepNext;
          cnt_d  = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            out_d   = finRes;
            state_d = DONE;
          end
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
      mcand_q <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      out_q   <= out_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign out       = out_q;

endmodule

// File: tb/tb_ysyx_25020042_muldiv.sv
// Directed bench for ysyx_25020042_muldiv: a vector table of M-extension ops with
// hand-computed results and latencies, plus backpressure, flush and reset sequences.
module tb_ysyx_25020042_muldiv;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic        busy;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic [31:0] edges;
  } vec_t;

  vec_t vecs [23];

  ysyx_25020042_muldiv #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .src1      (src1),
    .src2      (src2),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Presents one request; returns #1 after the accept edge with in_valid dropped.
  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    op       = o;
    src1     = a;
    src2     = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid, bounded; flags any in_ready high on the way.
  task automatic waitDone(input string name, output int edges, output logic rdySeen);
    edges   = 0;
    rdySeen = in_ready;
    while (!out_valid && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
      if (in_ready) rdySeen = 1'b1;
    end
    if (!out_valid) begin
      total++;
      bad++;
      $display("[TB] FAIL %s timeout: out_valid=%b after %0d edges", name, out_valid, edges);
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int   e;
    logic rdy;
    logic ok;

    vecs[0]  = '{MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 32'd32};
    vecs[1]  = '{MULH,   32'h80000000, 32'h80000000, 32'h40000000, 32'd32};
    vecs[2]  = '{MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd32};
    vecs[3]  = '{MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd32};
    vecs[4]  = '{DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'd32};
    vecs[5]  = '{REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'd32};
    vecs[6]  = '{DIVU,   32'd100,      32'd7,        32'd14,       32'd32};
    vecs[7]  = '{REMU,   32'd100,      32'd7,        32'd2,        32'd32};
    vecs[8]  = '{DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 32'd0};
    vecs[9]  = '{REMU,   32'd5,        32'd0,        32'd5,        32'd0};
    vecs[10] = '{DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0};
    vecs[11] = '{REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'd0};
    vecs[12] = '{MULH,   32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'd32};
    vecs[13] = '{MUL,    32'h12345678, 32'h00000010, 32'h23456780, 32'd32};
    vecs[14] = '{DIV,    32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd32};
    vecs[15] = '{REM,    32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd32};
    vecs[16] = '{DIV,    32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'd0};
    vecs[17] = '{REM,    32'h80000000, 32'h00000000, 32'h80000000, 32'd0};
    vecs[18] = '{MULHSU, 32'hFFFFFFFE, 32'h80000000, 32'hFFFFFFFF, 32'd32};
    vecs[19] = '{MULHU,  32'h80000000, 32'h00000004, 32'h00000002, 32'd32};
    vecs[20] = '{DIVU,   32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'd32};
    vecs[21] = '{REMU,   32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'd32};
    vecs[22] = '{MULH,   32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'd32};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op        = 3'b000;
    src1      = '0;
    src2      = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset out", out, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 23; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
      waitDone($sformatf("vec%0d", i), e, rdy);
      checkOutput($sformatf("vec%0d out", i), out, vecs[i].exp);
      checkOutput($sformatf("vec%0d latency", i), 32'(e), vecs[i].edges);
      checkOutput($sformatf("vec%0d in_ready low", i), 32'(rdy), 32'd0);
      consume();
    end

    // Backpressure: result must hold while a new request waits, and only be accepted after DONE->IDLE.
    applyStimulus(MUL, 32'd3, 32'd5);
    waitDone("bp mul", e, rdy);
    checkOutput("bp first out", out, 32'd15);
    in_valid = 1'b1;
    op       = DIVU;
    src1     = 32'd100;
    src2     = 32'd7;
    ok       = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (!out_valid || out !== 32'd15 || !busy) ok = 1'b0;
    end
    checkOutput("bp stable", 32'(ok), 32'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("bp idle in_ready", 32'(in_ready), 32'd1);
    checkOutput("bp out_valid drop", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("bp accepted busy", 32'(busy), 32'd1);
    waitDone("bp divu", e, rdy);
    checkOutput("bp divu out", out, 32'd14);
    checkOutput("bp divu latency", 32'(e), 32'd32);
    consume();

    // Flush a divide after 15 steps.
    applyStimulus(DIV, 32'd100, 32'd7);
    repeat (15) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checkOutput("flush busy", 32'(busy), 32'd0);
    checkOutput("flush in_ready", 32'(in_ready), 32'd1);
    ok = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) ok = 1'b1;
    end
    checkOutput("flush no out_valid", 32'(ok), 32'd0);

    // Flush together with a request in IDLE.
    in_valid = 1'b1;
    op       = MUL;
    src1     = 32'd9;
    src2     = 32'd9;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    checkOutput("flush+req no accept", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("flush+req still idle", 32'(in_ready), 32'd1);

    // Asynchronous reset in the middle of a multiply.
    applyStimulus(MUL, 32'h12345678, 32'd3);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    checkOutput("async rst in_ready", 32'(in_ready), 32'd1);
    checkOutput("async rst out_valid", 32'(out_valid), 32'd0);
    checkOutput("async rst busy", 32'(busy), 32'd0);
    checkOutput("async rst out", out, 32'd0);
    #3;
    rst_n = 1'b1;
    ok = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) ok = 1'b1;
    end
    checkOutput("async rst no result", 32'(ok), 32'd0);

    applyStimulus(MUL, 32'd6, 32'd7);
    waitDone("post reset mul", e, rdy);
    checkOutput("post reset mul out", out, 32'd42);
    consume();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
